// File: rtl/cdb_broadcast.sv
// Common Data Bus transmitter: one-entry result buffer per functional unit,
// round-robin arbitration and a registered (tag, value) broadcast.
module cdb_broadcast #(
    parameter int N_SRC  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src,
    output logic [N_SRC-1:0]        pending
);

    logic [N_SRC-1:0]  full;
    logic [TAG_W-1:0]  tag_q  [N_SRC];
    logic [DATA_W-1:0] data_q [N_SRC];
    logic [SRC_W-1:0]  rr_ptr;

    logic [N_SRC-1:0]  grant;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_any;
    logic [N_SRC-1:0]  load;

    function automatic logic [SRC_W-1:0] wrap_idx(input int base, input int offs);
        int s;
        s = base + offs;
        if (s >= N_SRC) begin
            s = s - N_SRC;
        end
        return SRC_W'(s);
    endfunction

    // Scan from rr_ptr upward, wrapping; the first full buffer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!grant_any && full[wrap_idx(int'(rr_ptr), k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(int'(rr_ptr), k);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A tag-0 result completes the handshake but is never buffered.
    always_comb begin
        src_ready = ~full | grant;
        load      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            load[i] = src_valid[i] & src_ready[i] & (src_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            full      <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (load[i]) begin
                    full[i]   <= 1'b1;
                    tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
                    data_q[i] <= src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
            // An idle bus carries tag 0 so no receiver matches a stale tag.
            if (grant_any) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= tag_q[grant_idx];
                cdb_data  <= data_q[grant_idx];
                cdb_src   <= grant_idx;
                rr_ptr    <= wrap_idx(int'(grant_idx), 1);
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_data  <= '0;
            end
        end
    end

    assign pending = full;

endmodule

// File: tb/tb_cdb_broadcast.sv
// Bench for cdb_broadcast: directed scenarios plus random traffic, all checked
// against a per-cycle behavioural model of the buffers and round-robin bus.
module tb_cdb_broadcast;

    localparam int N_SRC  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;
    localparam int QD     = 64;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    flush = 1'b0;
    logic [N_SRC-1:0]        src_valid = '0;
    logic [N_SRC*TAG_W-1:0]  src_tag = '0;
    logic [N_SRC*DATA_W-1:0] src_data = '0;
    logic [N_SRC-1:0]        src_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [SRC_W-1:0]        cdb_src;
    logic [N_SRC-1:0]        pending;

    int checks = 0;
    int errors = 0;

    cdb_broadcast #(.N_SRC(N_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .pending(pending)
    );

    always #5 clk = ~clk;

    // Source-side pending items, presented head-first until accepted.
    logic [TAG_W-1:0]  q_tag  [N_SRC][QD];
    logic [DATA_W-1:0] q_data [N_SRC][QD];
    int                q_head [N_SRC];
    int                q_tail [N_SRC];

    // Reference model: one slot per source, a "next to serve" pointer, bus.
    bit                m_full [N_SRC];
    logic [TAG_W-1:0]  m_tag  [N_SRC];
    logic [DATA_W-1:0] m_data [N_SRC];
    int                m_next = 0;
    bit                m_valid = 0;
    logic [TAG_W-1:0]  m_btag = '0;
    logic [DATA_W-1:0] m_bdata = '0;
    int                m_bsrc = 0;

    function automatic int model_winner();
        for (int k = 0; k < N_SRC; k++) begin
            if (m_full[(m_next + k) % N_SRC]) return (m_next + k) % N_SRC;
        end
        return -1;
    endfunction

    task automatic push(input int s, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        if (q_head[s] == q_tail[s]) begin
            q_head[s] = 0;
            q_tail[s] = 0;
        end
        q_tag[s][q_tail[s]]  = t;
        q_data[s][q_tail[s]] = d;
        q_tail[s]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N_SRC; i++) begin
            if (q_head[i] != q_tail[i]) begin
                src_valid[i]                 = 1'b1;
                src_tag[i*TAG_W +: TAG_W]    = q_tag[i][q_head[i]];
                src_data[i*DATA_W +: DATA_W] = q_data[i][q_head[i]];
            end else begin
                src_valid[i]                 = 1'b0;
                src_tag[i*TAG_W +: TAG_W]    = '0;
                src_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Present the queued items, then compare every output with the model.
    task automatic checkOutput();
        int w;
        logic [N_SRC-1:0] exp_ready;
        drive();
        @(negedge clk);
        w = model_winner();
        for (int i = 0; i < N_SRC; i++) exp_ready[i] = !m_full[i] || (w == i);
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_tag",   64'(cdb_tag),   64'(m_btag));
        chk("cdb_data",  64'(cdb_data),  64'(m_bdata));
        chk("cdb_src",   64'(cdb_src),   64'(m_bsrc));
        for (int i = 0; i < N_SRC; i++) begin
            chk("pending",   64'(pending[i]),   64'(m_full[i]));
            chk("src_ready", 64'(src_ready[i]), 64'(exp_ready[i]));
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic applyStimulus();
        int w;
        bit acc [N_SRC];
        w = model_winner();
        for (int i = 0; i < N_SRC; i++) acc[i] = src_valid[i] && (!m_full[i] || w == i);
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                m_full[i] = 0;
                q_head[i] = 0;
                q_tail[i] = 0;
            end
            m_next = 0; m_valid = 0; m_btag = '0; m_bdata = '0; m_bsrc = 0;
        end else if (flush) begin
            for (int i = 0; i < N_SRC; i++) m_full[i] = 0;
            m_valid = 0; m_btag = '0; m_bdata = '0;
        end else begin
            if (w >= 0) begin
                m_valid = 1; m_btag = m_tag[w]; m_bdata = m_data[w]; m_bsrc = w;
                m_full[w] = 0;
                m_next = (w + 1) % N_SRC;
            end else begin
                m_valid = 0; m_btag = '0; m_bdata = '0;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (acc[i] && q_tag[i][q_head[i]] != '0) begin
                    m_full[i] = 1;
                    m_tag[i]  = q_tag[i][q_head[i]];
                    m_data[i] = q_data[i][q_head[i]];
                end
            end
        end
        if (!rst) begin
            for (int i = 0; i < N_SRC; i++) if (acc[i]) q_head[i]++;
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic cycle();
        checkOutput();
        applyStimulus();
    endtask

    initial begin
        int bp_cnt;
        int bp_cyc [3];
        logic [TAG_W-1:0] bp_tag [3];
        int exp_v [6];
        int exp_t [6];
        int exp_p [6];

        for (int i = 0; i < N_SRC; i++) begin
            q_head[i] = 0;
            q_tail[i] = 0;
        end

        // Reset and check idle outputs.
        rst = 1'b1;
        drive();
        applyStimulus();
        checkOutput();
        chk("rst_valid",   64'(cdb_valid), 0);
        chk("rst_tag",     64'(cdb_tag),   0);
        chk("rst_pending", 64'(pending),   0);
        applyStimulus();

        // Single result through source 1.
        push(1, 4'd5, 32'h0000_00AA);
        checkOutput();
        chk("single_ready1", 64'(src_ready[1]), 1);
        applyStimulus();
        checkOutput();
        chk("single_pending", 64'(pending), 64'(4'b0010));
        chk("single_idle", 64'(cdb_valid), 0);
        applyStimulus();
        checkOutput();
        chk("single_valid", 64'(cdb_valid), 1);
        chk("single_tag",   64'(cdb_tag),   5);
        chk("single_data",  64'(cdb_data),  64'h0AA);
        chk("single_src",   64'(cdb_src),   1);
        applyStimulus();
        checkOutput();
        chk("single_after_valid", 64'(cdb_valid), 0);
        chk("single_after_tag",   64'(cdb_tag),   0);
        applyStimulus();

        // Round-robin from pointer 0 after a fresh reset.
        rst = 1'b1;
        cycle();
        for (int i = 0; i < N_SRC; i++) push(i, TAG_W'(i + 1), 32'h100 + i);
        cycle();
        cycle();
        for (int k = 0; k < N_SRC; k++) begin
            checkOutput();
            chk("rr_valid", 64'(cdb_valid), 1);
            chk("rr_src",   64'(cdb_src),   64'(k));
            chk("rr_tag",   64'(cdb_tag),   64'(k + 1));
            applyStimulus();
        end
        checkOutput();
        chk("rr_done", 64'(cdb_valid), 0);
        applyStimulus();

        // Back-pressure: source 2 competes with three always-busy sources.
        for (int k = 0; k < 8; k++) begin
            push(0, TAG_W'(k % 15 + 1), 32'h1000 + k);
            push(1, TAG_W'((k + 3) % 15 + 1), 32'h2000 + k);
            push(3, TAG_W'((k + 7) % 15 + 1), 32'h3000 + k);
        end
        push(2, 4'd6, 32'h206);
        push(2, 4'd7, 32'h207);
        push(2, 4'd8, 32'h208);
        bp_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            checkOutput();
            if (cdb_valid && cdb_src == 2 && bp_cnt < 3) begin
                bp_cyc[bp_cnt] = c;
                bp_tag[bp_cnt] = cdb_tag;
                bp_cnt++;
            end
            applyStimulus();
        end
        chk("bp_count", 64'(bp_cnt), 3);
        for (int k = 0; k < bp_cnt; k++) chk("bp_order", 64'(bp_tag[k]), 64'(k + 6));
        for (int k = 1; k < bp_cnt; k++) chk("bp_gap", 64'(bp_cyc[k] - bp_cyc[k-1]), 4);

        // Single source drained and refilled in the same cycle.
        push(0, 4'd9,  32'h9);
        push(0, 4'd10, 32'hA);
        push(0, 4'd11, 32'hB);
        exp_v = '{0, 0, 1, 1, 1, 0};
        exp_t = '{0, 0, 9, 10, 11, 0};
        exp_p = '{0, 1, 1, 1, 0, 0};
        for (int c = 0; c < 6; c++) begin
            checkOutput();
            chk("stream_valid",    64'(cdb_valid),  64'(exp_v[c]));
            chk("stream_tag",      64'(cdb_tag),    64'(exp_t[c]));
            chk("stream_pending0", 64'(pending[0]), 64'(exp_p[c]));
            applyStimulus();
        end

        // Flush squashes buffered results and the incoming one.
        push(0, 4'd12, 32'hC);
        push(3, 4'd13, 32'hD);
        cycle();
        push(1, 4'd14, 32'hE);
        flush = 1'b1;
        checkOutput();
        chk("flush_pending_before", 64'(pending), 64'(4'b1001));
        chk("flush_ready1", 64'(src_ready[1]), 1);
        applyStimulus();
        for (int c = 0; c < 4; c++) begin
            checkOutput();
            chk("flush_valid",   64'(cdb_valid), 0);
            chk("flush_pending", 64'(pending),   0);
            applyStimulus();
        end

        // Tag 0 is accepted but never buffered or broadcast.
        push(3, 4'd0, 32'hDEAD);
        checkOutput();
        chk("tag0_ready3", 64'(src_ready[3]), 1);
        applyStimulus();
        for (int c = 0; c < 2; c++) begin
            checkOutput();
            chk("tag0_pending3", 64'(pending[3]), 0);
            chk("tag0_valid",    64'(cdb_valid),  0);
            applyStimulus();
        end

        // Reset with three buffers full discards everything.
        push(0, 4'd1, 32'h11);
        push(1, 4'd2, 32'h22);
        push(2, 4'd3, 32'h33);
        cycle();
        rst = 1'b1;
        checkOutput();
        chk("rst3_pending_before", 64'(pending), 64'(4'b0111));
        applyStimulus();
        for (int c = 0; c < 4; c++) begin
            checkOutput();
            chk("rst3_valid",   64'(cdb_valid), 0);
            chk("rst3_tag",     64'(cdb_tag),   0);
            chk("rst3_data",    64'(cdb_data),  0);
            chk("rst3_src",     64'(cdb_src),   0);
            chk("rst3_pending", 64'(pending),   0);
            applyStimulus();
        end

        // Random traffic with occasional flush, reset and tag-0 results.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (q_head[i] == q_tail[i] && $urandom_range(0, 1) == 1)
                    push(i, TAG_W'($urandom_range(0, 15)), $urandom);
            end
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            cycle();
        end
        for (int c = 0; c < 12; c++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
